// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program-counter generator.
// Produces the instruction-ROM address and chip enable. It chooses between
// sequential fetch, a BTB prediction, an EX misprediction redirect and a
// control-unit flush. The prediction made for the current pc is exported so
// that EX can later detect a wrong path.
//
// The BTB is direct mapped: index = pc[IW+1:2], tag = pc[31:IW+2]. Each entry
// holds a valid bit, a tag, a 30-bit word-address target and a 2-bit
// saturating direction counter. Lookup reads the registered pc
// combinationally. The update lands on the clock edge, so a same-index lookup
// in the update cycle still sees the old contents (read-before-write).
module pc_gen #(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    input  logic        ex_mispredict,
    input  logic [31:0] ex_correct_pc,
    input  logic        ex_branch_valid,
    input  logic [31:0] ex_branch_pc,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_target,
    output logic [31:0] pc,
    output logic        ce,
    output logic        pdt_taken,
    output logic [31:0] pdt_target
);

    localparam int IW = $clog2(BTB_ENTRIES);
    localparam int TW = 30 - IW;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Force a candidate fetch address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

    // Counter value written on an update. A miss only writes on an
    // allocation, which starts the entry at weakly-taken.
    function automatic logic [1:0] next_count(input logic [1:0] cnt,
                                              input logic       hit,
                                              input logic       taken);
        logic [1:0] res;
        res = cnt;
        if (!hit) begin
            res = 2'b10;
        end else if (taken) begin
            res = (cnt == 2'b11) ? 2'b11 : cnt + 2'd1;
        end else begin
            res = (cnt == 2'b00) ? 2'b00 : cnt - 2'd1;
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0] pc_q, pc_d;
    logic        ce_q, ce_d;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [1:0]             cnt_q [BTB_ENTRIES];
    logic [TW-1:0]          tag_q [BTB_ENTRIES];
    logic [29:0]            tgt_q [BTB_ENTRIES];

    // ------------------------------------------------------------------
    // Lookup for the current fetch address
    // ------------------------------------------------------------------
    logic [IW-1:0] rd_idx;
    logic [TW-1:0] rd_tag;
    logic          rd_hit;
    logic [31:0]   pc_plus4;

    assign rd_idx   = pc_q[IW+1:2];
    assign rd_tag   = pc_q[31:IW+2];
    assign pc_plus4 = word_align(pc_q + 32'd4);

    // Nothing is fetched while ce is low, so no prediction is made then.
    assign rd_hit   = ce_q && valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);

    assign pdt_taken  = rd_hit && cnt_q[rd_idx][1];
    assign pdt_target = rd_hit ? {tgt_q[rd_idx], 2'b00} : pc_plus4;

    assign pc = pc_q;
    assign ce = ce_q;

    // ------------------------------------------------------------------
    // Update port, addressed by the resolved branch in EX
    // ------------------------------------------------------------------
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_tag;
    logic          wr_hit;
    logic          wr_alloc;
    logic          wr_count;
    logic          wr_target;
    logic [1:0]    wr_cnt_val;

    assign wr_idx = ex_branch_pc[IW+1:2];
    assign wr_tag = ex_branch_pc[31:IW+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // A not-taken miss leaves the entry alone; every other resolved branch
    // touches the counter. Only taken outcomes write a target.
    assign wr_alloc   = ex_branch_valid && ex_branch_taken && !wr_hit;
    assign wr_count   = ex_branch_valid && (wr_hit || ex_branch_taken);
    assign wr_target  = ex_branch_valid && ex_branch_taken;
    assign wr_cnt_val = next_count(cnt_q[wr_idx], wr_hit, ex_branch_taken);

    // Byte-offset bits of the branch address and target carry no information.
    logic unused_lsbs;
    assign unused_lsbs = ^{ex_branch_pc[1:0], ex_branch_target[1:0]};

    // ------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------

    // Pick the next fetch address; redirects override a stall, and the
    // first cycle out of reset re-fetches RESET_PC while ce comes up.
    always_comb begin
        pc_d = pc_q;
        ce_d = 1'b1;
        if (!ce_q) begin
            pc_d = pc_q;
        end else if (flush) begin
            pc_d = word_align(flush_pc);
        end else if (ex_mispredict) begin
            pc_d = word_align(ex_correct_pc);
        end else if (stall_if) begin
            pc_d = pc_q;
        end else if (pdt_taken) begin
            pc_d = word_align(pdt_target);
        end else begin
            pc_d = pc_plus4;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Fetch address and ROM chip enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
            ce_q <= 1'b0;
        end else begin
            pc_q <= pc_d;
            ce_q <= ce_d;
        end
    end

    // Entry valid bits; reset empties the whole table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_alloc) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Direction counters, reset to weakly-not-taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '{default: 2'b01};
        end else if (wr_count) begin
            cnt_q[wr_idx] <= wr_cnt_val;
        end
    end

    // Tags and targets are plain storage; valid gates their use. A write
    // is suppressed while reset is held so a pending update is discarded.
    always_ff @(posedge clk) begin
        if (!rst && wr_alloc) begin
            tag_q[wr_idx] <= wr_tag;
        end
        if (!rst && wr_target) begin
            tgt_q[wr_idx] <= ex_branch_target[31:2];
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by randomized
// traffic, all compared against a behavioural model of the fetch unit.
module tb_pc_gen;

    localparam int          N   = 16;
    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_if;
    logic        flush;
    logic [31:0] flush_pc;
    logic        ex_mispredict;
    logic [31:0] ex_correct_pc;
    logic        ex_branch_valid;
    logic [31:0] ex_branch_pc;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic [31:0] pc;
    logic        ce;
    logic        pdt_taken;
    logic [31:0] pdt_target;

    pc_gen #(.BTB_ENTRIES(N), .RESET_PC(RPC)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_if         (stall_if),
        .flush            (flush),
        .flush_pc         (flush_pc),
        .ex_mispredict    (ex_mispredict),
        .ex_correct_pc    (ex_correct_pc),
        .ex_branch_valid  (ex_branch_valid),
        .ex_branch_pc     (ex_branch_pc),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .pc               (pc),
        .ce               (ce),
        .pdt_taken        (pdt_taken),
        .pdt_target       (pdt_target)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the fetch pc, ce, and a table of remembered branches
    // keyed by slot, each remembering the full word address of its branch.
    logic [31:0] m_pc;
    logic        m_ce;
    logic [31:0] m_bpc [int];
    logic [31:0] m_tgt [int];
    int          m_cnt [int];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int slot(input logic [31:0] a);
        return int'((a >> 2) & 32'(N - 1));
    endfunction

    function automatic logic knows(input logic [31:0] a);
        logic r;
        r = 1'b0;
        if (m_bpc.exists(slot(a))) r = (m_bpc[slot(a)] == (a & 32'hFFFF_FFFC));
        return r;
    endfunction

    function automatic logic exp_taken();
        logic r;
        r = 1'b0;
        if (m_ce && knows(m_pc)) r = (m_cnt[slot(m_pc)] >= 2);
        return r;
    endfunction

    function automatic logic [31:0] exp_target();
        logic [31:0] r;
        r = m_pc + 32'd4;
        if (m_ce && knows(m_pc)) r = m_tgt[slot(m_pc)];
        return r;
    endfunction

    task automatic check_all(input string where);
        chk({where, ".pc"}, pc, m_pc);
        chk({where, ".ce"}, {31'b0, ce}, {31'b0, m_ce});
        chk({where, ".pdt_taken"}, {31'b0, pdt_taken}, {31'b0, exp_taken()});
        chk({where, ".pdt_target"}, pdt_target, exp_target());
    endtask

    task automatic clear_inputs();
        stall_if = 0; flush = 0; flush_pc = 0; ex_mispredict = 0; ex_correct_pc = 0;
        ex_branch_valid = 0; ex_branch_pc = 0; ex_branch_taken = 0; ex_branch_target = 0;
    endtask

    // One clock: predict the model's next state from the present inputs,
    // let the edge happen, then compare every output.
    task automatic step(input string where);
        logic [31:0] nxt;
        int s;
        if (!m_ce)              nxt = m_pc;
        else if (flush)         nxt = flush_pc & 32'hFFFF_FFFC;
        else if (ex_mispredict) nxt = ex_correct_pc & 32'hFFFF_FFFC;
        else if (stall_if)      nxt = m_pc;
        else if (exp_taken())   nxt = exp_target();
        else                    nxt = m_pc + 32'd4;
        if (ex_branch_valid) begin
            s = slot(ex_branch_pc);
            if (knows(ex_branch_pc)) begin
                if (ex_branch_taken) begin
                    m_cnt[s] = (m_cnt[s] == 3) ? 3 : m_cnt[s] + 1;
                    m_tgt[s] = ex_branch_target & 32'hFFFF_FFFC;
                end else begin
                    m_cnt[s] = (m_cnt[s] == 0) ? 0 : m_cnt[s] - 1;
                end
            end else if (ex_branch_taken) begin
                m_bpc[s] = ex_branch_pc & 32'hFFFF_FFFC;
                m_tgt[s] = ex_branch_target & 32'hFFFF_FFFC;
                m_cnt[s] = 2;
            end
        end
        @(posedge clk);
        #1;
        m_pc = nxt;
        m_ce = 1'b1;
        check_all(where);
    endtask

    task automatic model_reset();
        m_pc = RPC;
        m_ce = 1'b0;
        m_bpc.delete();
        m_tgt.delete();
        m_cnt.delete();
    endtask

    // Assert reset between edges, check it acts at once, hold it over the
    // given number of edges and release just after an edge.
    task automatic reset_pulse(input int edges);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst.pc", pc, RPC);
        chk("async_rst.ce", {31'b0, ce}, 32'd0);
        chk("async_rst.pdt_taken", {31'b0, pdt_taken}, 32'd0);
        for (int i = 0; i < edges; i++) begin
            @(posedge clk);
            #1;
            chk("in_rst.ce", {31'b0, ce}, 32'd0);
            chk("in_rst.pc", pc, RPC);
        end
        rst = 1'b0;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] a;
        a = 32'($urandom_range(0, 47)) * 32'd4;
        if ($urandom_range(0, 3) == 0) a = a + 32'h400;
        return a;
    endfunction

    initial begin
        clear_inputs();
        model_reset();

        // Reset held for three edges, then sequential fetch.
        #2 rst = 1'b1;
        #1;
        chk("por.pc", pc, RPC);
        chk("por.ce", {31'b0, ce}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("por_hold.ce", {31'b0, ce}, 32'd0);
        end
        rst = 1'b0;
        step("release");
        chk("release.pc0", pc, 32'h0);
        chk("release.ce1", {31'b0, ce}, 32'd1);
        step("seq");
        chk("seq.pc4", pc, 32'h4);
        step("seq");
        chk("seq.pc8", pc, 32'h8);

        // Stall at 0x10, then a mispredict while still stalled.
        for (int i = 0; i < 20 && m_pc != 32'h10; i++) step("seq");
        chk("reach_10", pc, 32'h10);
        stall_if = 1;
        for (int i = 0; i < 3; i++) step("stall");
        chk("stall_hold", pc, 32'h10);
        ex_mispredict = 1; ex_correct_pc = 32'h200;
        step("mis_in_stall");
        clear_inputs();
        chk("mis_in_stall.pc", pc, 32'h200);

        // Allocate a taken branch at 0x40 and fetch it.
        ex_branch_valid = 1; ex_branch_pc = 32'h40; ex_branch_taken = 1; ex_branch_target = 32'h100;
        step("alloc40");
        clear_inputs();
        flush = 1; flush_pc = 32'h40;
        step("goto40");
        clear_inputs();
        chk("pred40.taken", {31'b0, pdt_taken}, 32'd1);
        chk("pred40.target", pdt_target, 32'h100);
        step("follow40");
        chk("follow40.pc", pc, 32'h100);

        // Two not-taken outcomes drop the counter to strongly-not-taken.
        ex_branch_valid = 1; ex_branch_pc = 32'h40; ex_branch_taken = 0;
        step("decay");
        step("decay");
        clear_inputs();
        flush = 1; flush_pc = 32'h40;
        step("goto40b");
        clear_inputs();
        chk("decay40.taken", {31'b0, pdt_taken}, 32'd0);
        step("after_decay");
        chk("after_decay.pc", pc, 32'h44);

        // Flush beats mispredict, and the flush address is aligned.
        flush = 1; flush_pc = 32'h8000_0181; ex_mispredict = 1; ex_correct_pc = 32'h300;
        step("prio");
        clear_inputs();
        chk("prio.pc", pc, 32'h8000_0180);

        // Tag conflict on the same index evicts the older branch.
        ex_branch_valid = 1; ex_branch_pc = 32'h40; ex_branch_taken = 1; ex_branch_target = 32'h100;
        step("retrain40");
        ex_branch_pc = 32'h440; ex_branch_target = 32'h200;
        step("alloc440");
        clear_inputs();
        flush = 1; flush_pc = 32'h40;
        step("conflict40");
        chk("conflict40.taken", {31'b0, pdt_taken}, 32'd0);
        flush_pc = 32'h440;
        step("conflict440");
        clear_inputs();
        chk("conflict440.taken", {31'b0, pdt_taken}, 32'd1);
        chk("conflict440.target", pdt_target, 32'h200);

        // Address wrap at the top of the space.
        flush = 1; flush_pc = 32'hFFFF_FFFC;
        step("wrap_top");
        clear_inputs();
        chk("wrap_top.pc", pc, 32'hFFFF_FFFC);
        step("wrap");
        chk("wrap.pc", pc, 32'h0);

        // Asynchronous reset mid-run forgets trained branches.
        ex_branch_valid = 1; ex_branch_pc = 32'h120; ex_branch_taken = 1; ex_branch_target = 32'h80;
        step("alloc120");
        clear_inputs();
        flush = 1; flush_pc = 32'h120;
        step("goto120");
        clear_inputs();
        chk("pred120.taken", {31'b0, pdt_taken}, 32'd1);
        reset_pulse(1);
        step("rerelease");
        chk("rerelease.pc", pc, RPC);
        flush = 1; flush_pc = 32'h120;
        step("goto120b");
        clear_inputs();
        chk("forgot120.taken", {31'b0, pdt_taken}, 32'd0);

        // Randomized traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            stall_if        = ($urandom_range(0, 99) < 20);
            flush           = ($urandom_range(0, 99) < 4);
            flush_pc        = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFF0 : pick_addr();
            flush_pc        = flush_pc + 32'($urandom_range(0, 3));
            ex_mispredict   = ($urandom_range(0, 99) < 6);
            ex_correct_pc   = pick_addr() + 32'($urandom_range(0, 3));
            ex_branch_valid = ($urandom_range(0, 99) < 35);
            ex_branch_pc    = ($urandom_range(0, 1) == 0) ? m_pc : pick_addr();
            ex_branch_pc    = ex_branch_pc + 32'($urandom_range(0, 3));
            ex_branch_taken = ($urandom_range(0, 99) < 65);
            ex_branch_target = pick_addr() + 32'($urandom_range(0, 3));
            step("rand");
            if ($urandom_range(0, 999) == 0) reset_pulse($urandom_range(0, 2));
        end
        clear_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
